// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage dcache sequencer for LC-3b loads, stores, indirects and TRAP.
// Define MEM_STALL_CNT_EN to add the saturating stall_cycles counter output.
module mem_access_stage #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [3:0]        opcode_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] store_data_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [ADDR_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall_pipeline
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  localparam logic [3:0] LDB = 4'b0010, STB = 4'b0011, LDR = 4'b0110, STR = 4'b0111;
  localparam logic [3:0] LDI = 4'b1010, STI = 4'b1011, TRAP = 4'b1111;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
  state_t state;
  logic [3:0] op;
  logic a0;
  logic accept, st_in, ind, ld;
  logic [ADDR_W-1:0] fin;
  assign accept = valid_in && (opcode_in inside {LDR, LDB, LDI, STR, STB, STI, TRAP});
  assign st_in = opcode_in inside {STR, STB};
  assign ind = op inside {LDI, STI};
  assign ld = op inside {LDR, LDB, LDI, TRAP};
  assign fin = (op == LDB) ? {8'h00, a0 ? mem_rdata[15:8] : mem_rdata[7:0]} : mem_rdata;
  assign stall_pipeline = (state == IDLE && accept) || state == ACC1 || state == ACC2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op <= 4'b0000;
      a0 <= 1'b0;
      mem_address <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_byte_enable <= 2'b00;
      mem_wdata <= '0;
      load_data <= '0;
      load_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= ACC1;
          op <= opcode_in;
          a0 <= addr_in[0];
          mem_address <= {addr_in[ADDR_W-1:1], 1'b0};
          mem_read <= !st_in;
          mem_write <= st_in;
          mem_byte_enable <= (opcode_in == STB) ? (addr_in[0] ? 2'b10 : 2'b01) : 2'b11;
          mem_wdata <= (opcode_in == STB) ? {2{store_data_in[7:0]}} : store_data_in;
        end
        ACC1: if (mem_resp) begin
          if (ind) begin
            state <= ACC2;
            mem_address <= {mem_rdata[ADDR_W-1:1], 1'b0};
            mem_read <= op == LDI;
            mem_write <= op == STI;
            mem_byte_enable <= 2'b11;
          end else begin
            state <= DONE;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_byte_enable <= 2'b00;
            if (ld) load_data <= fin;
            load_valid <= ld;
          end
        end
        ACC2: if (mem_resp) begin
          state <= DONE;
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          mem_byte_enable <= 2'b00;
          if (ld) load_data <= fin;
          load_valid <= ld;
        end
        default: begin
          state <= IDLE;
          load_valid <= 1'b0;
        end
      endcase
    end
  end
`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_cycles <= 16'h0000;
    else if (stall_pipeline && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'h0001;
`endif
endmodule
